bus_window_ctrl: RTL and testbench
==================================

# bus_window_ctrl

Parametrised successor to the fixed CPU-bus enable decode. Samples the asynchronous host bus (address, phi2, rwbar) in the internal clock domain and resolves each bus cycle against a runtime-loadable table of NUM_WIN address windows per configuration. It drives RAM chip-select and write-enable, the FPGA data-pin output enable, and the host bus-buffer enable. Optionally it drives a mirror-write strobe for video-RAM capture. It sits between the CPU pins and the sram/vram arbitration muxes.

## Interface
- ADDR_W, 16, host address width
- NUM_CFG, 16, number of selectable configurations
- NUM_WIN, 4, windows per configuration (priority: lowest index wins)
- WR_SETTLE, 2, clk cycles after decode before the write strobe (range 1-15)
- clk  in  1  internal oscillator clock
- rst  in  1  reset; synchronous, active-high
- address  in  ADDR_W  host address bus
- phi2  in  1  host phase-2 clock (asynchronous)
- rwbar  in  1  host read (1) / write (0)
- halt  in  1  diagnostics halt; sampled only in IDLE
- config_sel  in  $clog2(NUM_CFG)  active configuration; sampled only in IDLE
- tbl_wr  in  1  one-cycle table write strobe
- tbl_cfg  in  $clog2(NUM_CFG)  table entry configuration index
- tbl_win  in  $clog2(NUM_WIN)  table entry window index
- tbl_start, tbl_end  in  ADDR_W each  window bounds, half-open [start,end)
- tbl_attr  in  2  00 OFF, 01 RAM, 10 ROM, 11 MIRROR
- ram_cs  out  1  RAM select for the current cycle
- ram_we  out  1  one-cycle RAM write strobe
- ram_addr  out  ADDR_W  latched host address
- data_oe  out  1  drive FPGA data pins (host reads)
- bus_en_n  out  1  active-low host bus-buffer enable
- win_hit  out  NUM_WIN  one-hot matched window, 0 if none
- win_offset  out  ADDR_W  ram_addr - start of matched window, modulo 2^ADDR_W
- mirror_we, mirror_addr  out  1, ADDR_W  mirror strobe and offset
- late_err  out  1  sticky; a write was aborted by phi2 falling

## Operation
- phi2 passes through a 2-flop synchroniser. A rising edge is detected on flop outputs.
- States and transitions:
  - IDLE -> LATCH on phi2 rise with halt=0. LATCH captures address, rwbar, config_sel.
  - LATCH -> DECODE (1 cycle). Compare against the active config's windows. A window with start>=end never matches. The lowest-index match wins.
  - DECODE -> ACCESS on a hit with attr != OFF. Otherwise -> HOLD with all outputs idle.
  - ACCESS, read: assert ram_cs and data_oe. bus_en_n=0 for RAM/ROM; MIRROR reads leave data_oe=0 (host memory answers). -> HOLD.
  - ACCESS, write: RAM asserts ram_cs and counts WR_SETTLE, then pulses ram_we for 1 cycle. ROM ignores the write (ram_cs=0, no strobe). MIRROR pulses mirror_we only (host memory also takes the write). -> HOLD.
  - HOLD: outputs stay until phi2 falls (synchronised), then all deassert -> IDLE.
- If phi2 falls before the write strobe issues: no strobe, late_err<=1, -> IDLE.
- Table writes take effect on the cycle after tbl_wr. A DECODE in the same cycle as tbl_wr to the active config uses the old entry.
- halt or config_sel changes mid-cycle are ignored until the next IDLE.

## Timing
- Reset values:
  - ram_cs, ram_we, data_oe, mirror_we, late_err = 0
  - win_hit, win_offset, ram_addr, mirror_addr = 0
  - bus_en_n = 1
  - every table entry cleared to OFF/0/0
- Reset mid-cycle: all outputs return to reset values the next clk; FSM goes to IDLE. A pending strobe is dropped and late_err is not set.
- Latency from the phi2 pin edge: 2 clk synchroniser + 1 LATCH + 1 DECODE. ram_cs rises 4 clk after the first clk sampling phi2 high.
- Write strobe (ram_we or mirror_we) fires WR_SETTLE clk after ACCESS entry.
- Deassert: outputs drop 3 clk after the first clk sampling phi2 low.
- Outputs are registered; no combinational path from pins to outputs.

## Configuration
- BUS_WINDOW_MIRROR_EN defined: MIRROR attribute is active; mirror_we/mirror_addr behave as above.
- Not defined: mirror_we and mirror_addr are tied 0; MIRROR windows decode as OFF.

## Structure
- Package bus_window_pkg: attribute enum (OFF/RAM/ROM/MIRROR), FSM state enum (IDLE/LATCH/DECODE/ACCESS/HOLD), default parameter constants.
- Sub-module bus_window_table: table register file, parallel compare, and priority encoder. Returns win_hit, attr, and start for the selected config.

## Test plan
- cfg0 win0=[0x8000,0x9000) RAM; host write 0x8123 data 0x5A -> ram_cs at +4 clk, single ram_we at +4+WR_SETTLE, win_offset=0x0123.
- cfg0 win1=[0xC000,0x10000-1) ROM; host write 0xC010 -> ram_cs=0, no ram_we, bus_en_n=1; a read of the same address -> data_oe=1, bus_en_n=0.
- Overlap: win0=[0x1000,0x2000) RAM, win2=[0x0000,0xFFFF) ROM; read 0x1800 -> win_hit=0001.
- MIRROR win=[0x8000,0x8800) with macro defined; write 0x8400 -> mirror_we pulse with mirror_addr=0x0400, ram_we=0, data_oe=0. Without the macro -> no strobe, win_hit=0.
- Write cycle with phi2 low after 3 clk, WR_SETTLE=4 -> no ram_we, late_err=1 until rst.
- rst asserted during HOLD of a read -> next clk data_oe=0, bus_en_n=1; halt=1 at the next phi2 rise -> no access.

Source files
------------

// File: rtl/bus_window_pkg.sv
// Shared types and default parameters for the bus window controller.
// The MIRROR attribute is only honoured when BUS_WINDOW_MIRROR_EN is defined.
package bus_window_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_NUM_CFG   = 16;
    localparam int DEF_NUM_WIN   = 4;
    localparam int DEF_WR_SETTLE = 2;

    typedef enum logic [1:0] {
        ATTR_OFF    = 2'b00,
        ATTR_RAM    = 2'b01,
        ATTR_ROM    = 2'b10,
        ATTR_MIRROR = 2'b11
    } attr_t;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        DECODE,
        ACCESS,
        HOLD
    } state_t;

endpackage

// File: rtl/bus_window_table.sv
// Runtime-loadable window table: per-configuration address windows with a
// half-open range compare and a lowest-index-wins priority encoder.
module bus_window_table
    import bus_window_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_CFG = DEF_NUM_CFG,
    parameter int NUM_WIN = DEF_NUM_WIN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tbl_wr,
    input  logic [$clog2(NUM_CFG)-1:0] tbl_cfg,
    input  logic [$clog2(NUM_WIN)-1:0] tbl_win,
    input  logic [ADDR_W-1:0]          tbl_start,
    input  logic [ADDR_W-1:0]          tbl_end,
    input  logic [1:0]                 tbl_attr,
    input  logic [$clog2(NUM_CFG)-1:0] sel_cfg,
    input  logic [ADDR_W-1:0]          sel_addr,
    output logic [NUM_WIN-1:0]         hit,
    output attr_t                      attr,
    output logic [ADDR_W-1:0]          start
);

    logic [ADDR_W-1:0] start_q [NUM_CFG][NUM_WIN];
    logic [ADDR_W-1:0] end_q   [NUM_CFG][NUM_WIN];
    attr_t             attr_q  [NUM_CFG][NUM_WIN];
    logic [NUM_WIN-1:0] match;
    logic               found;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CFG; c++) begin
                for (int w = 0; w < NUM_WIN; w++) begin
                    start_q[c][w] <= '0;
                    end_q[c][w]   <= '0;
                    attr_q[c][w]  <= ATTR_OFF;
                end
            end
        end else if (tbl_wr) begin
            start_q[tbl_cfg][tbl_win] <= tbl_start;
            end_q[tbl_cfg][tbl_win]   <= tbl_end;
            attr_q[tbl_cfg][tbl_win]  <= attr_t'(tbl_attr);
        end
    end

    // An empty or inverted window (start >= end) can never match.
    always_comb begin
        match = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            match[w] = (start_q[sel_cfg][w] < end_q[sel_cfg][w]) &&
                       (sel_addr >= start_q[sel_cfg][w]) &&
                       (sel_addr <  end_q[sel_cfg][w]);
        end
    end

    always_comb begin
        hit   = '0;
        attr  = ATTR_OFF;
        start = '0;
        found = 1'b0;
        for (int w = 0; w < NUM_WIN; w++) begin
            if (match[w] && !found) begin
                found  = 1'b1;
                hit[w] = 1'b1;
                attr   = attr_q[sel_cfg][w];
                start  = start_q[sel_cfg][w];
            end
        end
    end

endmodule

// File: rtl/bus_window_ctrl.sv
// Host-bus window decoder: synchronises phi2, decodes each bus cycle against the
// window table and drives registered RAM/bus controls. Macro: BUS_WINDOW_MIRROR_EN.
module bus_window_ctrl
    import bus_window_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_CFG   = DEF_NUM_CFG,
    parameter int NUM_WIN   = DEF_NUM_WIN,
    parameter int WR_SETTLE = DEF_WR_SETTLE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          address,
    input  logic                       phi2,
    input  logic                       rwbar,
    input  logic                       halt,
    input  logic [$clog2(NUM_CFG)-1:0] config_sel,
    input  logic                       tbl_wr,
    input  logic [$clog2(NUM_CFG)-1:0] tbl_cfg,
    input  logic [$clog2(NUM_WIN)-1:0] tbl_win,
    input  logic [ADDR_W-1:0]          tbl_start,
    input  logic [ADDR_W-1:0]          tbl_end,
    input  logic [1:0]                 tbl_attr,
    output logic                       ram_cs,
    output logic                       ram_we,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic                       data_oe,
    output logic                       bus_en_n,
    output logic [NUM_WIN-1:0]         win_hit,
    output logic [ADDR_W-1:0]          win_offset,
    output logic                       mirror_we,
    output logic [ADDR_W-1:0]          mirror_addr,
    output logic                       late_err
);

    state_t state, state_nxt;
    logic   phi2_s1, phi2_s2, phi2_s3;
    logic   phi2_rise, phi2_low;

    logic [ADDR_W-1:0]          lat_addr, lat_addr_nxt;
    logic                       lat_rw, lat_rw_nxt;
    logic [$clog2(NUM_CFG)-1:0] lat_cfg, lat_cfg_nxt;
    logic [3:0]                 settle_cnt, settle_nxt;
    attr_t                      acc_attr, acc_attr_nxt;

    logic                ram_cs_nxt, ram_we_nxt, data_oe_nxt, bus_en_n_nxt;
    logic                mirror_we_nxt, late_err_nxt, release_out;
    logic [NUM_WIN-1:0]  win_hit_nxt, tbl_hit;
    logic [ADDR_W-1:0]   win_offset_nxt, ram_addr_nxt, mirror_addr_nxt;
    logic [ADDR_W-1:0]   tbl_start_sel, offset;
    attr_t               tbl_attr_sel, eff_attr;

    // Left out of reset so a phi2 already high at reset release is not seen as a new edge.
    always_ff @(posedge clk) begin
        phi2_s1 <= phi2;
        phi2_s2 <= phi2_s1;
        phi2_s3 <= phi2_s2;
    end

    assign phi2_rise = phi2_s2 & ~phi2_s3;
    assign phi2_low  = ~phi2_s3;

    bus_window_table #(
        .ADDR_W  (ADDR_W),
        .NUM_CFG (NUM_CFG),
        .NUM_WIN (NUM_WIN)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .tbl_wr    (tbl_wr),
        .tbl_cfg   (tbl_cfg),
        .tbl_win   (tbl_win),
        .tbl_start (tbl_start),
        .tbl_end   (tbl_end),
        .tbl_attr  (tbl_attr),
        .sel_cfg   (lat_cfg),
        .sel_addr  (lat_addr),
        .hit       (tbl_hit),
        .attr      (tbl_attr_sel),
        .start     (tbl_start_sel)
    );

`ifdef BUS_WINDOW_MIRROR_EN
    assign eff_attr = tbl_attr_sel;
`else
    assign eff_attr = (tbl_attr_sel == ATTR_MIRROR) ? ATTR_OFF : tbl_attr_sel;
`endif

    assign offset = lat_addr - tbl_start_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_addr    <= '0;
            lat_rw      <= 1'b1;
            lat_cfg     <= '0;
            settle_cnt  <= '0;
            acc_attr    <= ATTR_OFF;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            data_oe     <= 1'b0;
            bus_en_n    <= 1'b1;
            win_hit     <= '0;
            win_offset  <= '0;
            ram_addr    <= '0;
            mirror_we   <= 1'b0;
            mirror_addr <= '0;
            late_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            lat_addr    <= lat_addr_nxt;
            lat_rw      <= lat_rw_nxt;
            lat_cfg     <= lat_cfg_nxt;
            settle_cnt  <= settle_nxt;
            acc_attr    <= acc_attr_nxt;
            ram_cs      <= ram_cs_nxt;
            ram_we      <= ram_we_nxt;
            data_oe     <= data_oe_nxt;
            bus_en_n    <= bus_en_n_nxt;
            win_hit     <= win_hit_nxt;
            win_offset  <= win_offset_nxt;
            ram_addr    <= ram_addr_nxt;
            mirror_we   <= mirror_we_nxt;
            mirror_addr <= mirror_addr_nxt;
            late_err    <= late_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        lat_addr_nxt    = lat_addr;
        lat_rw_nxt      = lat_rw;
        lat_cfg_nxt     = lat_cfg;
        settle_nxt      = settle_cnt;
        acc_attr_nxt    = acc_attr;
        ram_cs_nxt      = ram_cs;
        data_oe_nxt     = data_oe;
        bus_en_n_nxt    = bus_en_n;
        win_hit_nxt     = win_hit;
        win_offset_nxt  = win_offset;
        ram_addr_nxt    = ram_addr;
        mirror_addr_nxt = mirror_addr;
        ram_we_nxt      = 1'b0;
        mirror_we_nxt   = 1'b0;
        late_err_nxt    = late_err;
        release_out     = 1'b0;

        case (state)
            IDLE: begin
                if (phi2_rise && !halt) begin
                    state_nxt    = LATCH;
                    lat_addr_nxt = address;
                    lat_rw_nxt   = rwbar;
                    lat_cfg_nxt  = config_sel;
                end
            end
            LATCH: state_nxt = DECODE;
            DECODE: begin
                if ((|tbl_hit) && (eff_attr != ATTR_OFF)) begin
                    state_nxt      = ACCESS;
                    acc_attr_nxt   = eff_attr;
                    settle_nxt     = 4'(WR_SETTLE);
                    win_hit_nxt    = tbl_hit;
                    win_offset_nxt = offset;
                    ram_addr_nxt   = lat_addr;
                    if (lat_rw) begin
                        ram_cs_nxt   = 1'b1;
                        data_oe_nxt  = (eff_attr != ATTR_MIRROR);
                        bus_en_n_nxt = (eff_attr == ATTR_MIRROR);
                    end else begin
                        case (eff_attr)
                            ATTR_RAM: begin
                                ram_cs_nxt   = 1'b1;
                                bus_en_n_nxt = 1'b0;
                            end
                            ATTR_MIRROR: begin
                                bus_en_n_nxt    = 1'b0;
                                mirror_addr_nxt = offset;
                            end
                            default: ;
                        endcase
                    end
                end else begin
                    state_nxt = HOLD;
                end
            end
            ACCESS: begin
                // A pending write strobe loses to phi2 falling, even on its own cycle.
                if (lat_rw || acc_attr == ATTR_ROM) begin
                    state_nxt = HOLD;
                end else if (phi2_low) begin
                    state_nxt    = IDLE;
                    release_out  = 1'b1;
                    late_err_nxt = 1'b1;
                end else if (settle_cnt == 4'd1) begin
                    state_nxt = HOLD;
                    if (acc_attr == ATTR_RAM) begin
                        ram_we_nxt = 1'b1;
                    end else begin
                        mirror_we_nxt = 1'b1;
                    end
                end else begin
                    settle_nxt = settle_cnt - 4'd1;
                end
            end
            HOLD: begin
                if (phi2_low) begin
                    state_nxt   = IDLE;
                    release_out = 1'b1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                release_out = 1'b1;
            end
        endcase

        if (release_out) begin
            ram_cs_nxt      = 1'b0;
            data_oe_nxt     = 1'b0;
            bus_en_n_nxt    = 1'b1;
            win_hit_nxt     = '0;
            win_offset_nxt  = '0;
            ram_addr_nxt    = '0;
            mirror_addr_nxt = '0;
        end
    end

endmodule

// File: tb/tb_bus_window_ctrl.sv
// Self-checking bench for bus_window_ctrl: a table model predicts each host
// bus cycle and the expectation is queued, then popped when the DUT responds.
module tb_bus_window_ctrl;

    localparam int WR_SETTLE = 4;
`ifdef BUS_WINDOW_MIRROR_EN
    localparam bit MIRROR_EN = 1'b1;
`else
    localparam bit MIRROR_EN = 1'b0;
`endif

    typedef struct {
        logic        ram_cs;
        logic        data_oe;
        logic        bus_en_n;
        logic [3:0]  win_hit;
        logic [15:0] win_offset;
        logic [15:0] ram_addr;
        logic [15:0] mirror_addr;
        int          we_at;
        int          mwe_at;
        logic        late;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, phi2, rwbar, halt, tbl_wr;
    logic [15:0] address, tbl_start, tbl_end;
    logic [3:0]  config_sel, tbl_cfg;
    logic [1:0]  tbl_win, tbl_attr;
    logic        ram_cs, ram_we, data_oe, bus_en_n, mirror_we, late_err;
    logic [15:0] ram_addr, win_offset, mirror_addr;
    logic [3:0]  win_hit;

    logic [15:0] m_start [16][4];
    logic [15:0] m_end   [16][4];
    logic [1:0]  m_attr  [16][4];
    logic        exp_late;
    exp_t        exp_q [$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    bus_window_ctrl #(
        .ADDR_W(16), .NUM_CFG(16), .NUM_WIN(4), .WR_SETTLE(WR_SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .address(address), .phi2(phi2), .rwbar(rwbar),
        .halt(halt), .config_sel(config_sel), .tbl_wr(tbl_wr), .tbl_cfg(tbl_cfg),
        .tbl_win(tbl_win), .tbl_start(tbl_start), .tbl_end(tbl_end), .tbl_attr(tbl_attr),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .data_oe(data_oe),
        .bus_en_n(bus_en_n), .win_hit(win_hit), .win_offset(win_offset),
        .mirror_we(mirror_we), .mirror_addr(mirror_addr), .late_err(late_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clearModel();
        for (int c = 0; c < 16; c++) begin
            for (int w = 0; w < 4; w++) begin
                m_start[c][w] = '0;
                m_end[c][w]   = '0;
                m_attr[c][w]  = 2'b00;
            end
        end
    endtask

    task automatic loadWindow(input logic [3:0] c, input logic [1:0] w,
                              input logic [15:0] s, input logic [15:0] e, input logic [1:0] a);
        @(negedge clk);
        tbl_cfg = c; tbl_win = w; tbl_start = s; tbl_end = e; tbl_attr = a; tbl_wr = 1'b1;
        @(negedge clk);
        tbl_wr = 1'b0;
        m_start[c][w] = s; m_end[c][w] = e; m_attr[c][w] = a;
    endtask

    // Indices count negedges after phi2 is raised; outputs appear at index 5.
    function automatic exp_t modelDecode(input logic [3:0] c, input logic [15:0] a,
                                         input logic rw, input int high_clks, input logic hlt);
        exp_t       e;
        int         hitw;
        logic [1:0] at;
        e.ram_cs = 1'b0; e.data_oe = 1'b0; e.bus_en_n = 1'b1; e.win_hit = '0;
        e.win_offset = '0; e.ram_addr = '0; e.mirror_addr = '0;
        e.we_at = -1; e.mwe_at = -1; e.late = 1'b0;
        hitw = -1;
        for (int w = 0; w < 4; w++) begin
            if (hitw < 0 && m_start[c][w] < m_end[c][w] && a >= m_start[c][w] && a < m_end[c][w])
                hitw = w;
        end
        if (hlt || hitw < 0) return e;
        at = m_attr[c][hitw];
        if (!MIRROR_EN && at == 2'b11) at = 2'b00;
        if (at == 2'b00) return e;
        e.win_hit    = 4'(1 << hitw);
        e.win_offset = a - m_start[c][hitw];
        e.ram_addr   = a;
        if (rw) begin
            e.ram_cs   = 1'b1;
            e.data_oe  = (at != 2'b11);
            e.bus_en_n = (at == 2'b11);
        end else if (at != 2'b10) begin
            e.bus_en_n = 1'b0;
            if (at == 2'b01) e.ram_cs = 1'b1;
            if (high_clks + 3 <= 4 + WR_SETTLE) begin
                e.late = 1'b1;
            end else if (at == 2'b01) begin
                e.we_at = 5 + WR_SETTLE;
            end else begin
                e.mwe_at      = 5 + WR_SETTLE;
                e.mirror_addr = e.win_offset;
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input string tag, input logic [3:0] c, input logic [15:0] a,
                                 input logic rw, input int high_clks);
        exp_t e;
        int   we_n, we_at, mwe_n, mwe_at, last;
        e = modelDecode(c, a, rw, high_clks, halt);
        exp_late = exp_late | e.late;
        e.late   = exp_late;
        exp_q.push_back(e);
        last  = (high_clks + 6 > 12) ? high_clks + 6 : 12;
        we_n  = 0; we_at = -1; mwe_n = 0; mwe_at = -1;
        @(negedge clk);
        config_sel = c; address = a; rwbar = rw; phi2 = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == high_clks) phi2 = 1'b0;
            if (k == 5) begin
                if (exp_q.size() == 0) begin
                    checkOutput({tag, ".sb_empty"}, 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput({tag, ".ram_cs"},   32'(ram_cs),     32'(e.ram_cs));
                    checkOutput({tag, ".data_oe"},  32'(data_oe),    32'(e.data_oe));
                    checkOutput({tag, ".bus_en_n"}, 32'(bus_en_n),   32'(e.bus_en_n));
                    checkOutput({tag, ".win_hit"},  32'(win_hit),    32'(e.win_hit));
                    checkOutput({tag, ".offset"},   32'(win_offset), 32'(e.win_offset));
                    checkOutput({tag, ".ram_addr"}, 32'(ram_addr),   32'(e.ram_addr));
                end
            end
            if (ram_we) begin
                we_n++;
                if (we_at < 0) we_at = k;
            end
            if (mirror_we) begin
                mwe_n++;
                if (mwe_at < 0) begin
                    mwe_at = k;
                    checkOutput({tag, ".mirror_addr"}, 32'(mirror_addr), 32'(e.mirror_addr));
                end
            end
        end
        checkOutput({tag, ".ram_we_at"},  32'(we_at),  32'(e.we_at));
        checkOutput({tag, ".ram_we_n"},   32'(we_n),   (e.we_at >= 0) ? 32'd1 : 32'd0);
        checkOutput({tag, ".mir_we_at"},  32'(mwe_at), 32'(e.mwe_at));
        checkOutput({tag, ".mir_we_n"},   32'(mwe_n),  (e.mwe_at >= 0) ? 32'd1 : 32'd0);
        checkOutput({tag, ".late_err"},   32'(late_err), 32'(e.late));
        checkOutput({tag, ".idle_cs"},    32'(ram_cs),   32'd0);
        checkOutput({tag, ".idle_bus"},   32'(bus_en_n), 32'd1);
    endtask

    initial begin
        rst = 1'b1; phi2 = 1'b0; rwbar = 1'b1; halt = 1'b0; address = '0; config_sel = '0;
        tbl_wr = 1'b0; tbl_cfg = '0; tbl_win = '0; tbl_start = '0; tbl_end = '0; tbl_attr = '0;
        exp_late = 1'b0;
        clearModel();
        repeat (3) @(negedge clk);
        checkOutput("rst.ram_cs",   32'(ram_cs),      32'd0);
        checkOutput("rst.ram_we",   32'(ram_we),      32'd0);
        checkOutput("rst.data_oe",  32'(data_oe),     32'd0);
        checkOutput("rst.bus_en_n", 32'(bus_en_n),    32'd1);
        checkOutput("rst.mirror",   32'(mirror_we),   32'd0);
        checkOutput("rst.late",     32'(late_err),    32'd0);
        checkOutput("rst.win_hit",  32'(win_hit),     32'd0);
        checkOutput("rst.offset",   32'(win_offset),  32'd0);
        checkOutput("rst.ram_addr", 32'(ram_addr),    32'd0);
        checkOutput("rst.mir_addr", 32'(mirror_addr), 32'd0);
        rst = 1'b0;

        loadWindow(4'd0, 2'd0, 16'h8000, 16'h9000, 2'b01);
        loadWindow(4'd0, 2'd1, 16'hC000, 16'hFFFF, 2'b10);
        loadWindow(4'd1, 2'd0, 16'h1000, 16'h2000, 2'b01);
        loadWindow(4'd1, 2'd2, 16'h0000, 16'hFFFF, 2'b10);
        loadWindow(4'd2, 2'd0, 16'h8000, 16'h8800, 2'b11);
        loadWindow(4'd3, 2'd0, 16'h5000, 16'h5000, 2'b01);

        applyStimulus("ram_wr",     4'd0, 16'h8123, 1'b0, 12);
        applyStimulus("ram_rd_top", 4'd0, 16'h8FFF, 1'b1, 12);
        applyStimulus("ram_rd_end", 4'd0, 16'h9000, 1'b1, 12);
        applyStimulus("rom_wr",     4'd0, 16'hC010, 1'b0, 12);
        applyStimulus("rom_rd",     4'd0, 16'hC010, 1'b1, 12);
        applyStimulus("ovl_lo",     4'd1, 16'h1800, 1'b1, 12);
        applyStimulus("ovl_hi",     4'd1, 16'h2800, 1'b1, 12);
        applyStimulus("mirror_wr",  4'd2, 16'h8400, 1'b0, 12);
        applyStimulus("empty_win",  4'd3, 16'h5000, 1'b1, 12);
        applyStimulus("other_cfg",  4'd3, 16'h8123, 1'b1, 12);
        applyStimulus("late_wr",    4'd0, 16'h8200, 1'b0, 3);
        applyStimulus("after_late", 4'd0, 16'h8300, 1'b1, 12);

        // Reset while a read sits in HOLD with phi2 still high.
        @(negedge clk);
        config_sel = 4'd0; address = 16'h8010; rwbar = 1'b1; phi2 = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("hold.data_oe", 32'(data_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst.data_oe",  32'(data_oe),  32'd0);
        checkOutput("midrst.bus_en_n", 32'(bus_en_n), 32'd1);
        checkOutput("midrst.ram_cs",   32'(ram_cs),   32'd0);
        checkOutput("midrst.late",     32'(late_err), 32'd0);
        rst = 1'b0; phi2 = 1'b0; exp_late = 1'b0;
        clearModel();
        repeat (4) @(negedge clk);

        loadWindow(4'd0, 2'd0, 16'h8000, 16'h9000, 2'b01);
        halt = 1'b1;
        applyStimulus("halted",   4'd0, 16'h8010, 1'b1, 12);
        halt = 1'b0;
        applyStimulus("unhalted", 4'd0, 16'h8010, 1'b1, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
